rocc_cmd_queue: RTL and testbench

- Command buffer between the core's RoCC command port and the neurosynapse accelerator's command input (inst[31:5] / rs1 / rs2 / valid / ready).
- Decouples core issue from accelerator latency: accepts up to DEPTH commands back-to-back, then replays them in order on the accelerator-side valid/ready handshake.
- Reports occupancy and a busy flag for core fence/stall logic.

---
 rtl/rocc_pkg.sv | 32 +++
 rtl/rocc_fifo.sv | 60 ++++++
 rtl/rocc_cmd_queue.sv | 100 ++++++++++
 tb/tb_rocc_cmd_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_pkg.sv
// Shared RoCC definitions for the command queue: funct7 codes, instruction
// field layout and the packed command record.
package rocc_pkg;

    localparam logic [6:0] FN_OP1 = 7'd1;
    localparam logic [6:0] FN_OP2 = 7'd2;
    localparam logic [6:0] FN_OP3 = 7'd3;
    localparam logic [6:0] FN_OP4 = 7'd4;
    localparam logic [6:0] FN_OP5 = 7'd5;

    // RoCC instruction field layout (bit positions within inst[31:0])
    localparam int unsigned F7_MSB     = 31;
    localparam int unsigned F7_LSB     = 25;
    localparam int unsigned RS2_MSB    = 24;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned XD_BIT     = 14;
    localparam int unsigned XS1_BIT    = 13;
    localparam int unsigned XS2_BIT    = 12;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned OPCODE_LSB = 0;

    typedef struct packed {
        logic [31:5] inst;
        logic [63:0] rs1;
        logic [63:0] rs2;
    } rocc_cmd_t;

endpackage

// File: rtl/rocc_fifo.sv
// Generic synchronous show-ahead FIFO; pushes when full and pops when empty
// are ignored. Synchronous active-low reset clears pointers and storage.
module rocc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Full blocks the push even when a pop lands in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rocc_cmd_queue.sv
// RoCC command buffer between core and neurosynapse accelerator.
// Optional funct7 legality filter: define ROCC_CMD_ILLEGAL_FILTER_EN.
module rocc_cmd_queue
    import rocc_pkg::*;
#(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_FUNCT7 = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [INST_WIDTH-1:0]     cmd_inst,
    input  logic [DATA_WIDTH-1:0]     cmd_rs1,
    input  logic [DATA_WIDTH-1:0]     cmd_rs2,
    output logic                      acc_valid,
    input  logic                      acc_ready,
    output logic [INST_WIDTH-6:0]     acc_inst,
    output logic [DATA_WIDTH-1:0]     acc_rs1,
    output logic [DATA_WIDTH-1:0]     acc_rs2,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      busy
`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
    ,
    output logic                      illegal_pulse,
    output logic [7:0]                illegal_cnt
`endif
);

    localparam int unsigned AW = INST_WIDTH - 5;
    localparam int unsigned EW = AW + 2 * DATA_WIDTH;

    logic          accept;
    logic          keep;
    logic          full, empty;
    logic [EW-1:0] wr_entry, head;
    logic          unused_ok;

    assign accept    = cmd_valid && cmd_ready;
    assign wr_entry  = {cmd_inst[INST_WIDTH-1:5], cmd_rs1, cmd_rs2};
    assign unused_ok = ^cmd_inst[4:0];

`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
    localparam logic [6:0] MAXF = 7'(MAX_FUNCT7);

    logic [6:0] funct7;
    logic       legal;
    logic       pulse_q, pulse_d;
    logic [7:0] cnt_q, cnt_d;

    assign funct7 = cmd_inst[F7_MSB:F7_LSB];
    assign legal  = (funct7 >= FN_OP1) && (funct7 <= MAXF);
    assign keep   = legal;

    // Illegal commands still handshake with the core; they just never reach storage.
    always_comb begin
        pulse_d = accept && !legal;
        cnt_d   = cnt_q;
        if (pulse_d && (cnt_q != '1)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign illegal_pulse = pulse_q;
    assign illegal_cnt   = cnt_q;
`else
    assign keep = 1'b1;
`endif

    rocc_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept && keep),
        .push_data_i (wr_entry),
        .pop_i       (acc_ready),
        .pop_data_o  (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

    assign cmd_ready = !full;
    assign acc_valid = !empty;
    assign busy      = (count != '0);
    assign {acc_inst, acc_rs1, acc_rs2} = head;

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Self-checking bench for rocc_cmd_queue: vector table plus scoreboard of
// expected accelerator-side commands.
module tb_rocc_cmd_queue;
    import rocc_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_inst = '0;
    logic [63:0] cmd_rs1 = '0;
    logic [63:0] cmd_rs2 = '0;
    logic        acc_valid;
    logic        acc_ready = 1'b0;
    logic [26:0] acc_inst;
    logic [63:0] acc_rs1;
    logic [63:0] acc_rs2;
    logic [2:0]  count;
    logic        busy;
`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
    logic        illegal_pulse;
    logic [7:0]  illegal_cnt;
    int unsigned exp_ill_cnt = 0;
`endif

    rocc_cmd_queue #(
        .INST_WIDTH (32),
        .DATA_WIDTH (64),
        .DEPTH      (DEPTH),
        .MAX_FUNCT7 (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_inst  (cmd_inst),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_inst  (acc_inst),
        .acc_rs1   (acc_rs1),
        .acc_rs2   (acc_rs2),
        .count     (count),
        .busy      (busy)
`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
        ,
        .illegal_pulse (illegal_pulse),
        .illegal_cnt   (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    rocc_cmd_t sb[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] make_inst(input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, 3'b011, 5'd3, 7'h0B};
    endfunction

    function automatic bit is_legal(input logic [6:0] f7);
`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
        return (f7 >= 7'd1) && (f7 <= 7'd5);
`else
        return f7 == f7;
`endif
    endfunction

    task automatic drive(input logic v, input logic [6:0] f7, input logic [63:0] r1, input logic [63:0] r2);
        cmd_valid = v;
        cmd_inst  = make_inst(f7);
        cmd_rs1   = r1;
        cmd_rs2   = r2;
    endtask

    // One clock: update the scoreboard from the handshakes about to happen,
    // then check the post-edge state against the model.
    task automatic step();
        bit        enq, deq, drop;
        rocc_cmd_t exp;
        enq  = cmd_valid && cmd_ready;
        deq  = acc_valid && acc_ready;
        drop = enq && !is_legal(cmd_inst[31:25]);
        if (deq) begin
            if (sb.size() == 0) begin
                chk("pop_without_entry", 160'(1), 160'(0));
            end else begin
                exp = sb.pop_front();
                chk("head", 160'({acc_inst, acc_rs1, acc_rs2}), 160'(exp));
            end
        end
        if (enq && !drop) sb.push_back({cmd_inst[31:5], cmd_rs1, cmd_rs2});
        @(posedge clk); #1;
        chk("count", 160'(count), 160'(sb.size()));
        chk("acc_valid", 160'(acc_valid), 160'(sb.size() != 0));
        chk("busy", 160'(busy), 160'(sb.size() != 0));
        chk("cmd_ready", 160'(cmd_ready), 160'(sb.size() != DEPTH));
`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
        if (drop && exp_ill_cnt < 255) exp_ill_cnt++;
        chk("illegal_pulse", 160'(illegal_pulse), 160'(drop));
        chk("illegal_cnt", 160'(illegal_cnt), 160'(exp_ill_cnt));
`endif
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        acc_ready = 1'b0;
        @(posedge clk); #1;
        sb.delete();
`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
        exp_ill_cnt = 0;
`endif
        rst = 1'b1;
        chk("rst_count", 160'(count), 160'(0));
        chk("rst_acc_valid", 160'(acc_valid), 160'(0));
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_cmd_ready", 160'(cmd_ready), 160'(1));
        chk("rst_acc_fields", 160'({acc_inst, acc_rs1, acc_rs2}), 160'(0));
    endtask

    typedef struct {
        logic       v;
        logic       r;
        logic [6:0] f7;
        logic [2:0] cnt;
        logic       crdy;
        logic       av;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // {cmd_valid, acc_ready, funct7, count, cmd_ready, acc_valid} after the edge
        tbl[0]  = '{1, 0, 7'd1, 3'd1, 1, 1};
        tbl[1]  = '{0, 1, 7'd0, 3'd0, 1, 0};
        tbl[2]  = '{1, 0, 7'd1, 3'd1, 1, 1};
        tbl[3]  = '{1, 0, 7'd2, 3'd2, 1, 1};
        tbl[4]  = '{1, 0, 7'd3, 3'd3, 1, 1};
        tbl[5]  = '{1, 0, 7'd4, 3'd4, 0, 1};
        tbl[6]  = '{1, 0, 7'd5, 3'd4, 0, 1};
        tbl[7]  = '{1, 1, 7'd5, 3'd3, 1, 1};
        tbl[8]  = '{1, 0, 7'd5, 3'd4, 0, 1};
        tbl[9]  = '{0, 1, 7'd0, 3'd3, 1, 1};
        tbl[10] = '{0, 1, 7'd0, 3'd2, 1, 1};
        tbl[11] = '{0, 1, 7'd0, 3'd1, 1, 1};
        tbl[12] = '{0, 1, 7'd0, 3'd0, 1, 0};
        tbl[13] = '{0, 1, 7'd0, 3'd0, 1, 0};

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            if (i == 0)
                drive(tbl[i].v, tbl[i].f7, 64'h3F800000_40000000, 64'h40400000_40800000);
            else
                drive(tbl[i].v, tbl[i].f7, {32'hC0DE0000 + 32'(i), 32'h11110000},
                      {32'hBEEF0000 + 32'(i), 32'h22220000});
            acc_ready = tbl[i].r;
            step();
            chk($sformatf("vec%0d_count", i), 160'(count), 160'(tbl[i].cnt));
            chk($sformatf("vec%0d_cmd_ready", i), 160'(cmd_ready), 160'(tbl[i].crdy));
            chk($sformatf("vec%0d_acc_valid", i), 160'(acc_valid), 160'(tbl[i].av));
            if (i == 0)
                chk("vec0_head", 160'({acc_inst, acc_rs1, acc_rs2}),
                    160'({make_inst(7'd1) >> 5, 64'h3F800000_40000000, 64'h40400000_40800000}));
        end

        // Steady push/pop at count=1; pointers wrap several times.
        acc_ready = 1'b0;
        drive(1'b1, 7'd1, 64'h0, 64'h1);
        step();
        acc_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 7'(1 + (i % 5)), 64'(i) << 8, ~64'(i));
            step();
            chk("stream_count", 160'(count), 160'(1));
        end
        drive(1'b0, 7'd0, '0, '0);
        step();
        chk("stream_drained", 160'(count), 160'(0));

        // Reset with three entries held.
        acc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'(i + 1), 64'hAAAA + 64'(i), 64'h5555 + 64'(i));
            step();
        end
        chk("pre_reset_count", 160'(count), 160'(3));
        do_reset();

`ifdef ROCC_CMD_ILLEGAL_FILTER_EN
        acc_ready = 1'b0;
        drive(1'b1, 7'd0, 64'h10, 64'h20); step();
        chk("drop_f7_0_pulse", 160'(illegal_pulse), 160'(1));
        drive(1'b1, 7'd6, 64'h30, 64'h40); step();
        chk("drop_f7_6_pulse", 160'(illegal_pulse), 160'(1));
        drive(1'b1, 7'd2, 64'h50, 64'h60); step();
        chk("keep_f7_2_pulse", 160'(illegal_pulse), 160'(0));
        drive(1'b0, 7'd0, '0, '0); step();
        chk("filter_count", 160'(count), 160'(1));
        chk("filter_cnt", 160'(illegal_cnt), 160'(2));
        chk("filter_head_f7", 160'(acc_inst[26:20]), 160'(2));
        acc_ready = 1'b1;
        step();
`endif

        chk("sb_empty_end", 160'(sb.size()), 160'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
